// File: rtl/dmem_subword_if.sv
// Request/response bundle between the load/store unit and dmem_subword.
interface dmem_subword_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_subword.sv
// Word-organised data RAM with RISC-V sub-word loads/stores, byte-lane masking,
// misalignment/illegal-op detection and a configurable wait-state handshake.
module dmem_subword #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic           clk,
  input logic           rst,
  dmem_subword_if.slave bus
);
  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned AW   = IdxW + 2;
  localparam logic [3:0]  CntInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept, commit;
  logic          acc_we;
  logic [2:0]    acc_f3;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [1:0]    off;
  logic [IdxW-1:0] idx;
  logic [31:0]   word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          err;
  logic [3:0]    mask;
  logic [31:0]   wd;
  logic [31:0]   ld;

  logic unused_addr;
  assign unused_addr = ^bus.req_addr[ADDR_W-1:AW];

  assign accept = (state_q == StIdle) && bus.req_valid;
  assign commit = (state_d == StResp) && (state_q != StResp);

  // With no wait states the access commits on the accept edge, so decode straight
  // from the request port while idle and from the latched copy otherwise.
  assign acc_we    = (state_q == StIdle) ? bus.req_we               : we_q;
  assign acc_f3    = (state_q == StIdle) ? bus.req_funct3           : f3_q;
  assign acc_addr  = (state_q == StIdle) ? bus.req_addr[AW-1:0]     : addr_q;
  assign acc_wdata = (state_q == StIdle) ? bus.req_wdata            : wdata_q;

  assign off    = acc_addr[1:0];
  assign idx    = acc_addr[AW-1:2];
  assign word   = mem[idx];
  assign byte_v = word[{off, 3'b000} +: 8];
  assign half_v = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          cnt_d   = CntInit;
          state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err  = 1'b0;
    mask = 4'b0000;
    wd   = acc_wdata;
    ld   = 32'd0;
    if (acc_we) begin
      case (acc_f3)
        3'b000: begin
          mask = 4'b0001 << off;
          wd   = {4{acc_wdata[7:0]}};
        end
        3'b001: begin
          wd = {2{acc_wdata[15:0]}};
          if (off[0]) err  = 1'b1;
          else        mask = off[1] ? 4'b1100 : 4'b0011;
        end
        3'b010: begin
          if (off != 2'b00) err  = 1'b1;
          else              mask = 4'b1111;
        end
        default: err = 1'b1;
      endcase
    end else begin
      case (acc_f3)
        3'b000: ld = {{24{byte_v[7]}}, byte_v};
        3'b100: ld = {24'd0, byte_v};
        3'b001: begin
          if (off[0]) err = 1'b1;
          else        ld  = {{16{half_v[15]}}, half_v};
        end
        3'b101: begin
          if (off[0]) err = 1'b1;
          else        ld  = {16'd0, half_v};
        end
        3'b010: begin
          if (off != 2'b00) err = 1'b1;
          else              ld  = word;
        end
        default: err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr[AW-1:0];
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        rdata_q <= err ? 32'd0 : ld;
        err_q   <= err;
      end
    end
  end

  // RAM is never reset; mask is all-zero for loads and erroring stores.
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: doc/dmem_subword.md
# dmem_subword

Parametrised data memory for the single-cycle/multi-cycle RISC-V core. It replaces the word-only data memory with RISC-V sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW), byte-lane write masking and misalignment/illegal-op detection. It adds a valid/ready request port with a configurable wait-state count, so the core can model slower memory. It sits between the core's load/store unit and the word-organised RAM array.

## Interface
Parameters:
- `ADDR_W`, default 32: request address width.
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words. Must be a power of 2, at least 2.
- `WAIT_CYCLES`, default 0: extra wait states per access, range 0–15.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V funct3 of the load/store.
- `req_addr` input `ADDR_W`: byte address.
- `req_wdata` input 32: store data. The low byte/half is used for SB/SH.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: load result, extended to 32 bits. 0 for stores and errors.
- `resp_err` output 1: misaligned access or illegal funct3. Valid with `resp_valid`.

## Operation
- Word index = `req_addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH_WORDS*4`.
- Byte offset = `req_addr[1:0]`.
- Load funct3 decode:
  - 000 LB: sign-extend byte at offset.
  - 001 LH: sign-extend half at `offset[1]`.
  - 010 LW.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Store funct3 decode:
  - 000 SB: write one lane.
  - 001 SH: write two lanes.
  - 010 SW: write all four lanes.
  - Unwritten lanes keep their old contents.
- Errors:
  - Any other funct3 is illegal.
  - Misaligned: half access with `addr[0]`=1; word access with `addr[1:0]`≠0.
  - On error: no RAM write, `resp_err`=1, `resp_rdata`=0.
- FSM states IDLE, WAIT, RESP:
  - IDLE: `req_ready`=1. When `req_valid` is high, the request is latched (we, funct3, addr, wdata). Next state is WAIT if `WAIT_CYCLES`>0, else RESP.
  - WAIT: a 4-bit down-counter is loaded with `WAIT_CYCLES`-1 on accept. The FSM moves to RESP on the edge where the counter is 0.
  - RESP: `resp_valid`=1 for exactly one cycle, `req_ready`=0. Next state is IDLE.
- The RAM access (store commit and load data capture) occurs on the edge that enters RESP. Response fields are registered at that edge.
- Reset:
  - Returns the FSM to IDLE and clears `resp_valid`, `resp_err` and `resp_rdata` to 0, and the wait counter to 0.
  - RAM contents are not cleared.
  - A request in WAIT when `rst` is asserted is abandoned; its store is never committed.
- `req_valid` while `req_ready`=0 is ignored. The master must hold the request until it sees `req_ready` high.

## Timing
- Accept edge T (IDLE, `req_valid` high). `resp_valid` is high in cycle T+1+`WAIT_CYCLES`.
- `req_ready` returns high in cycle T+2+`WAIT_CYCLES`.
- Throughput: one access per 2+`WAIT_CYCLES` cycles.
- A store is visible to a load accepted in the cycle after its `resp_valid`.
- `req_ready` = (state==IDLE), decoded from registered state only, with no combinational path from `req_*`.
- In the first cycle after `rst` deasserts: `req_ready`=1, `resp_valid`=0.
- If `rst` is high on the same edge as an accept or a RESP transition, `rst` wins: no accept, no write.

## Test plan
1. Default params:
   - SW 0xDEADBEEF @0x10, then LW @0x10.
   - Required: each `resp_valid` exactly one cycle after accept; LW returns 0xDEADBEEF; `resp_err`=0.
2. Sub-word (word @0x20 preloaded 0x8899AABB by SW):
   - LB @0x21 → 0xFFFFFFAA; LBU @0x21 → 0x000000AA; LH @0x22 → 0xFFFF8899; LHU @0x22 → 0x00008899.
   - SB 0x11 @0x23, then LW @0x20 → 0x1199AABB.
3. Misalignment:
   - SH @0x31 → `resp_err`=1, `resp_rdata`=0, and LW @0x30 is unchanged.
   - LW @0x32 → `resp_err`=1.
   - funct3=011 load → `resp_err`=1.
4. WAIT_CYCLES=3:
   - Accept at T → `resp_valid` at T+4 and `req_ready` at T+5.
   - `req_valid` held high throughout → the second request is accepted exactly at T+5.
5. Reset mid-operation (WAIT_CYCLES=3):
   - SW 0x12345678 @0x40 over existing 0; assert `rst` one cycle after accept.
   - Required: no `resp_valid`; LW @0x40 afterwards → 0.
6. Wrap:
   - DEPTH_WORDS=1024; SW 0xCAFEF00D @0x1004.
   - LW @0x0004 → 0xCAFEF00D.
